// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the write-back bundle that feeds the register file.
package mips_pkg;

   localparam int unsigned NB_REG      = 32;
   localparam int unsigned NB_REG_ADDR = 5;
   localparam int unsigned REG_ZERO    = 0;

   typedef struct packed {
      logic [NB_REG_ADDR-1:0] reg_dest;
      logic                   reg_we;
      logic [NB_REG-1:0]      data;
   } wb_bundle_t;

endpackage

// File: rtl/rf_read_mux.sv
// One register-file read port: register 0 reads as zero, an in-flight commit to the
// same address is forwarded, otherwise the stored word is returned.
module rf_read_mux
   import mips_pkg::*;
#(
   parameter int unsigned NB_REG      = mips_pkg::NB_REG,
   parameter int unsigned NB_REG_ADDR = mips_pkg::NB_REG_ADDR
) (
   input  logic [NB_REG_ADDR-1:0]                  addr,
   input  logic [2**NB_REG_ADDR-1:0][NB_REG-1:0]   regs,
   input  logic                                    commit,
   input  logic [NB_REG_ADDR-1:0]                  wr_dest,
   input  logic [NB_REG-1:0]                       wr_data,
   output logic [NB_REG-1:0]                       data
);

   always_comb begin
      data = regs[addr];
      if (commit && (addr == wr_dest))
         data = wr_data;
      if (addr == NB_REG_ADDR'(REG_ZERO))
         data = '0;
   end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register bank: two combinational operand ports with write-through
// bypass, one registered debug read port, and a committed-write counter.
module register_file
   import mips_pkg::*;
#(
   parameter int unsigned NB_REG      = mips_pkg::NB_REG,
   parameter int unsigned NB_REG_ADDR = mips_pkg::NB_REG_ADDR,
   parameter int unsigned NB_WR_CNT   = 16
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [NB_REG-1:0]      i_wb_data,
   input  logic [NB_REG_ADDR-1:0] i_wb_reg_dest,
   input  logic                   i_wb_reg_we,
   input  logic                   i_halt,
   input  logic [NB_REG_ADDR-1:0] i_rs_addr,
   input  logic [NB_REG_ADDR-1:0] i_rt_addr,
   output logic [NB_REG-1:0]      o_rs_data,
   output logic [NB_REG-1:0]      o_rt_data,
   input  logic                   i_dbg_req,
   input  logic [NB_REG_ADDR-1:0] i_dbg_addr,
   output logic [NB_REG-1:0]      o_dbg_data,
   output logic                   o_dbg_valid,
   output logic [NB_WR_CNT-1:0]   o_wr_count
);

   localparam int unsigned N_REGS = 2**NB_REG_ADDR;

   logic [N_REGS-1:0][NB_REG-1:0] regs;
   logic                          commit;
   logic [NB_REG-1:0]             dbg_rd;

   assign commit = i_wb_reg_we && !i_halt && (i_wb_reg_dest != NB_REG_ADDR'(REG_ZERO));

   rf_read_mux #(.NB_REG(NB_REG), .NB_REG_ADDR(NB_REG_ADDR)) u_rs_mux (
      .addr    (i_rs_addr),
      .regs    (regs),
      .commit  (commit),
      .wr_dest (i_wb_reg_dest),
      .wr_data (i_wb_data),
      .data    (o_rs_data)
   );

   rf_read_mux #(.NB_REG(NB_REG), .NB_REG_ADDR(NB_REG_ADDR)) u_rt_mux (
      .addr    (i_rt_addr),
      .regs    (regs),
      .commit  (commit),
      .wr_dest (i_wb_reg_dest),
      .wr_data (i_wb_data),
      .data    (o_rt_data)
   );

   rf_read_mux #(.NB_REG(NB_REG), .NB_REG_ADDR(NB_REG_ADDR)) u_dbg_mux (
      .addr    (i_dbg_addr),
      .regs    (regs),
      .commit  (commit),
      .wr_dest (i_wb_reg_dest),
      .wr_data (i_wb_data),
      .data    (dbg_rd)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         regs        <= '0;
         o_dbg_data  <= '0;
         o_dbg_valid <= 1'b0;
         o_wr_count  <= '0;
      end else begin
         if (commit) begin
            regs[i_wb_reg_dest] <= i_wb_data;
            o_wr_count          <= o_wr_count + NB_WR_CNT'(1);
         end
         o_dbg_valid <= i_dbg_req;
         if (i_dbg_req)
            o_dbg_data <= dbg_rd;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table for the operand ports, a queue
// scoreboard for the registered debug port, and sequences for reset, streaming and wrap.
module tb_register_file;

   logic        clock;
   logic        reset;
   logic [31:0] wb_data;
   logic [4:0]  wb_reg_dest;
   logic        wb_reg_we;
   logic        halt;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_valid;
   logic [3:0]  wr_count;

   register_file #(.NB_REG(32), .NB_REG_ADDR(5), .NB_WR_CNT(4)) dut (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_wb_data     (wb_data),
      .i_wb_reg_dest (wb_reg_dest),
      .i_wb_reg_we   (wb_reg_we),
      .i_halt        (halt),
      .i_rs_addr     (rs_addr),
      .i_rt_addr     (rt_addr),
      .o_rs_data     (rs_data),
      .o_rt_data     (rt_data),
      .i_dbg_req     (dbg_req),
      .i_dbg_addr    (dbg_addr),
      .o_dbg_data    (dbg_data),
      .o_dbg_valid   (dbg_valid),
      .o_wr_count    (wr_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [31:0] m_regs [32];
   logic [3:0]  m_count;
   logic        exp_valid;
   logic [31:0] exp_hold;
   logic [31:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_commit();
      return wb_reg_we && !halt && (wb_reg_dest != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_commit() && a == wb_reg_dest) return wb_data;
      return m_regs[a];
   endfunction

   // Apply one rising edge with the currently driven inputs, advance the model, check
   // the registered outputs, and return at the following falling edge.
   task automatic tick();
      logic cm;
      cm = m_commit();
      if (reset && dbg_req) sb.push_back(m_read(dbg_addr));
      @(posedge clock);
      if (!reset) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_count   = 4'd0;
         exp_valid = 1'b0;
         exp_hold  = 32'd0;
         sb.delete();
      end else begin
         if (cm) begin
            m_regs[wb_reg_dest] = wb_data;
            m_count = m_count + 4'd1;
         end
         exp_valid = dbg_req;
      end
      #1;
      check("dbg_valid", {31'd0, dbg_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         if (sb.size() > 0) exp_hold = sb.pop_front();
         else check("dbg_scoreboard_empty", 32'd1, 32'd0);
      end
      check("dbg_data", dbg_data, exp_hold);
      check("wr_count", {28'd0, wr_count}, {28'd0, m_count});
      @(negedge clock);
   endtask

   task automatic idle();
      wb_reg_we = 1'b0; halt = 1'b0; dbg_req = 1'b0;
      wb_reg_dest = 5'd0; wb_data = 32'd0;
   endtask

   task automatic write(input logic [4:0] d, input logic [31:0] v);
      idle();
      wb_reg_we = 1'b1; wb_reg_dest = d; wb_data = v;
      tick();
   endtask

   typedef struct {
      logic        we;
      logic        hlt;
      logic [4:0]  dest;
      logic [31:0] data;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        dreq;
      logic [4:0]  daddr;
      logic [31:0] exp_rs;
      logic [31:0] exp_rt;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'd0,       4'd1};
      vecs[1] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1};
      vecs[2] = '{1'b1, 1'b0, 5'd7, 32'h11,      5'd7, 5'd5, 1'b0, 5'd0, 32'h11,       32'hDEADBEEF, 4'd2};
      vecs[3] = '{1'b1, 1'b0, 5'd7, 32'h22,      5'd7, 5'd7, 1'b1, 5'd7, 32'h22,       32'h22,       4'd3};
      vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd7, 5'd0, 1'b0, 5'd0, 32'h22,       32'd0,        4'd3};
      vecs[5] = '{1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 32'd0,       32'd0,        4'd3};
      vecs[6] = '{1'b1, 1'b0, 5'd3, 32'h10,      5'd3, 5'd7, 1'b0, 5'd0, 32'h10,       32'h22,       4'd4};
      vecs[7] = '{1'b1, 1'b1, 5'd3, 32'h55,      5'd3, 5'd3, 1'b1, 5'd3, 32'h10,       32'h10,       4'd4};
      vecs[8] = '{1'b0, 1'b0, 5'd0, 32'h0,       5'd3, 5'd1, 1'b1, 5'd3, 32'h10,       32'd0,        4'd4};

      reset = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
      idle();
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_count = 4'd0; exp_valid = 1'b0; exp_hold = 32'd0;
      @(negedge clock);
      tick();
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         wb_reg_we = vecs[i].we;   halt = vecs[i].hlt;
         wb_reg_dest = vecs[i].dest; wb_data = vecs[i].data;
         rs_addr = vecs[i].rs;     rt_addr = vecs[i].rt;
         dbg_req = vecs[i].dreq;   dbg_addr = vecs[i].daddr;
         #1;
         check($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
         check($sformatf("vec%0d_rt", i), rt_data, vecs[i].exp_rt);
         tick();
         check($sformatf("vec%0d_cnt", i), {28'd0, wr_count}, {28'd0, vecs[i].exp_cnt});
      end

      // Debug streaming: held request over three addresses, then released.
      write(5'd1, 32'hA);
      write(5'd2, 32'hB);
      write(5'd3, 32'hC);
      idle();
      dbg_req = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         dbg_addr = 5'(a);
         tick();
         check($sformatf("stream%0d_valid", a), {31'd0, dbg_valid}, 32'd1);
         check($sformatf("stream%0d_data", a), dbg_data, 32'hA + 32'(a - 1));
      end
      dbg_req = 1'b0;
      tick();
      check("stream_hold", dbg_data, 32'hC);

      // Reset with a write and a debug request pending: both discarded.
      wb_reg_we = 1'b1; wb_reg_dest = 5'd9; wb_data = 32'h99;
      dbg_req = 1'b1; dbg_addr = 5'd5;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      idle();
      check("rst_valid", {31'd0, dbg_valid}, 32'd0);
      check("rst_dbg", dbg_data, 32'd0);
      check("rst_cnt", {28'd0, wr_count}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a); rt_addr = 5'(31 - a);
         #1;
         check($sformatf("rst_rs%0d", a), rs_data, 32'd0);
         check($sformatf("rst_rt%0d", 31 - a), rt_data, 32'd0);
      end

      // Counter wrap: 17 commits on a 4-bit counter lands on 1.
      for (int n = 0; n < 17; n++)
         write(5'((n % 31) + 1), 32'(n + 100));
      idle();
      check("wrap_cnt", {28'd0, wr_count}, 32'd1);
      rs_addr = 5'd17; rt_addr = 5'd1;
      #1;
      check("wrap_rs17", rs_data, 32'd116);
      check("wrap_rt1", rt_data, 32'd100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
